// File: rtl/seven_segment_mux_counter.sv
// seven_segment_mux_counter: prescaled cascaded BCD up/down counter that drives a
// time-multiplexed common-segment seven-segment display.
// Optional build macro SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN blanks leading-zero
// digits (digit 0 is always shown); when undefined every digit is displayed.
module seven_segment_mux_counter #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned TICK_DIV   = 27000000,
    parameter int unsigned SCAN_DIV   = 27000,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_down,
    input  logic                  clear,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BW = 4 * DIGITS;

    localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]     SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_ZERO  = 7'b1111110;
    localparam logic [DIGITS-1:0] AN_FIRST  = DIGITS'(1);
    localparam logic [6:0]        SEG_RST   = ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
    localparam logic [DIGITS-1:0] AN_RST    = ACTIVE_LOW ? ~AN_FIRST : AN_FIRST;

    logic [PW-1:0]     presc_q;
    logic [SW-1:0]     scan_q;
    logic [IW-1:0]     idx_q;
    logic              tick_c;
    logic [BW-1:0]     bcd_step_c;
    logic              wrap_c;
    logic [3:0]        dig_c;
    logic [3:0]        sel_dig_c;
    logic              blank_c;
    logic [6:0]        seg_pat_c;
    logic [DIGITS-1:0] an_pat_c;

    // Segment pattern {a..g} for one BCD digit, all-off for non-decimal codes
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign tick_c = en & (presc_q == PRESC_MAX);

    // Ripple increment/decrement across all digits; wrap_c survives only if every digit wrapped
    always_comb begin
        bcd_step_c = bcd;
        wrap_c     = 1'b1;
        dig_c      = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            dig_c = bcd[4*i +: 4];
            if (wrap_c) begin
                if (up_down) begin
                    if (dig_c >= 4'd9) begin
                        bcd_step_c[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_step_c[4*i +: 4] = dig_c + 4'd1;
                        wrap_c               = 1'b0;
                    end
                end else begin
                    if (dig_c == 4'd0) begin
                        bcd_step_c[4*i +: 4] = 4'd9;
                    end else begin
                        bcd_step_c[4*i +: 4] = dig_c - 4'd1;
                        wrap_c               = 1'b0;
                    end
                end
            end
        end
    end

    // Prescaler, count register and wrap pulse; clear beats tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            bcd     <= '0;
            carry   <= 1'b0;
        end else if (clear) begin
            presc_q <= '0;
            bcd     <= '0;
            carry   <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (tick_c) begin
                presc_q <= '0;
                bcd     <= bcd_step_c;
                carry   <= wrap_c;
            end else if (en) begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // Free-running scan timer and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SCAN_MAX) begin
            scan_q <= '0;
            idx_q  <= (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end else begin
            scan_q <= scan_q + SW'(1);
        end
    end

    // Pick the digit addressed by the scan index
    always_comb begin
        sel_dig_c = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == idx_q) begin
                sel_dig_c = bcd[4*i +: 4];
            end
        end
    end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    logic lead_zero_c;

    // Blank the selected digit when it and everything above it are zero
    always_comb begin
        lead_zero_c = 1'b1;
        blank_c     = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            lead_zero_c = lead_zero_c & (bcd[4*i +: 4] == 4'd0);
            if ((i > 0) && (IW'(i) == idx_q) && lead_zero_c) begin
                blank_c = 1'b1;
            end
        end
    end
`else
    assign blank_c = 1'b0;
`endif

    assign seg_pat_c = blank_c ? 7'b0000000 : decode(sel_dig_c);
    assign an_pat_c  = AN_FIRST << idx_q;

    // Segment and enable registers share one index/count snapshot so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_RST;
            an  <= AN_RST;
        end else begin
            seg <= ACTIVE_LOW ? ~seg_pat_c : seg_pat_c;
            an  <= ACTIVE_LOW ? ~an_pat_c : an_pat_c;
        end
    end

endmodule
